// File: rtl/noc_pkg.sv
// Shared packet layout helpers for the mesh PE adapter: field offsets, pack/unpack, stats width.
// Packing works on a wide scratch vector; callers size-cast to their real packet width.
package noc_pkg;

  localparam int CNT_W     = 16;
  localparam int PKT_MAX_W = 256;

  typedef logic [PKT_MAX_W-1:0] pkt_max_t;

  function automatic int x_lsb();
    return 0;
  endfunction

  function automatic int y_lsb(input int xs);
    return xs;
  endfunction

  function automatic int payload_lsb(input int xs, input int ys);
    return xs + ys;
  endfunction

  function automatic pkt_max_t field_mask(input int w);
    return (pkt_max_t'(1) << w) - pkt_max_t'(1);
  endfunction

  function automatic pkt_max_t pack(input pkt_max_t payload, input pkt_max_t dx,
                                    input pkt_max_t dy, input int xs, input int ys);
    return (payload << payload_lsb(xs, ys)) |
           ((dy & field_mask(ys)) << y_lsb(xs)) |
           ((dx & field_mask(xs)) << x_lsb());
  endfunction

  function automatic pkt_max_t unpack_x(input pkt_max_t pkt, input int xs);
    return (pkt >> x_lsb()) & field_mask(xs);
  endfunction

  function automatic pkt_max_t unpack_y(input pkt_max_t pkt, input int xs, input int ys);
    return (pkt >> y_lsb(xs)) & field_mask(ys);
  endfunction

  function automatic pkt_max_t unpack_payload(input pkt_max_t pkt, input int xs, input int ys);
    return pkt >> payload_lsb(xs, ys);
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO, head visible combinationally (zero-latency read), one push/pop per cycle.
// Full/empty come from the registered count only, so a full FIFO refuses a push even while popping.
module noc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dat   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage is deliberately not reset; the count alone marks entries valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/noc_pe_adapter.sv
// PE <-> mesh switch adapter: packs/queues injections, buffers ejections and strips headers; head
// visible the cycle after push, ready from registered occupancy. NOC_ADAPTER_STATS_EN adds counters.
module noc_pe_adapter
  import noc_pkg::*;
#(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 32,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int INJ_DEPTH   = 4,
  parameter int EJ_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [data_width-1:0]  s_data,
  input  logic [x_size-1:0]      s_dest_x,
  input  logic [y_size-1:0]      s_dest_y,
  output logic                   o_valid_sw,
  input  logic                   i_ready_sw,
  output logic [total_width-1:0] o_data_sw,
  input  logic                   i_valid_sw,
  output logic                   o_ready_sw,
  input  logic [total_width-1:0] i_data_sw,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [data_width-1:0]  m_data,
  output logic                   o_misroute
`ifdef NOC_ADAPTER_STATS_EN
  ,
  output logic [CNT_W-1:0]       inj_cnt,
  output logic [CNT_W-1:0]       ej_cnt
`endif
);

  localparam logic [x_size-1:0] LP_X = x_size'(x_coord);
  localparam logic [y_size-1:0] LP_Y = y_size'(y_coord);

  logic                   w_inj_push;
  logic                   w_inj_pop;
  logic                   w_inj_full;
  logic                   w_inj_empty;
  logic [total_width-1:0] w_inj_pkt;
  logic                   w_ej_push;
  logic                   w_ej_pop;
  logic                   w_ej_full;
  logic                   w_ej_empty;
  logic [total_width-1:0] w_ej_head;
  logic [x_size-1:0]      w_ej_x;
  logic [y_size-1:0]      w_ej_y;
  logic                   r_misroute;

  assign w_inj_pkt = total_width'(pack(PKT_MAX_W'(s_data), PKT_MAX_W'(s_dest_x),
                                       PKT_MAX_W'(s_dest_y), x_size, y_size));

  assign s_ready    = ~w_inj_full;
  assign w_inj_push = s_valid & s_ready;
  assign o_valid_sw = ~w_inj_empty;
  assign w_inj_pop  = o_valid_sw & i_ready_sw;

  noc_fifo #(.WIDTH(total_width), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_inj_push),
    .i_pop   (w_inj_pop),
    .i_dat   (w_inj_pkt),
    .o_dat   (o_data_sw),
    .o_full  (w_inj_full),
    .o_empty (w_inj_empty)
  );

  assign o_ready_sw = ~w_ej_full;
  assign w_ej_push  = i_valid_sw & o_ready_sw;
  assign m_valid    = ~w_ej_empty;
  assign w_ej_pop   = m_valid & m_ready;
  assign m_data     = data_width'(unpack_payload(PKT_MAX_W'(w_ej_head), x_size, y_size));

  noc_fifo #(.WIDTH(total_width), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ej_push),
    .i_pop   (w_ej_pop),
    .i_dat   (i_data_sw),
    .o_dat   (w_ej_head),
    .o_full  (w_ej_full),
    .o_empty (w_ej_empty)
  );

  // A misrouted packet is still delivered; the flag only records that it happened.
  assign w_ej_x = x_size'(unpack_x(PKT_MAX_W'(i_data_sw), x_size));
  assign w_ej_y = y_size'(unpack_y(PKT_MAX_W'(i_data_sw), x_size, y_size));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misroute <= 1'b0;
    end else if (w_ej_push && ((w_ej_x != LP_X) || (w_ej_y != LP_Y))) begin
      r_misroute <= 1'b1;
    end
  end

  assign o_misroute = r_misroute;

`ifdef NOC_ADAPTER_STATS_EN
  logic [CNT_W-1:0] r_inj_cnt;
  logic [CNT_W-1:0] r_ej_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inj_cnt <= '0;
      r_ej_cnt  <= '0;
    end else begin
      if (w_inj_pop && (r_inj_cnt != '1)) r_inj_cnt <= r_inj_cnt + CNT_W'(1);
      if (w_ej_push && (r_ej_cnt != '1))  r_ej_cnt  <= r_ej_cnt + CNT_W'(1);
    end
  end

  assign inj_cnt = r_inj_cnt;
  assign ej_cnt  = r_ej_cnt;
`endif

endmodule
